// File: rtl/bus_arbiter.sv
// Two-master bus arbiter sharing one downstream bus port (breq/bgnt/bstart/bdone handshake).
// Optional BUSY watchdog enabled by defining BUS_ARB_TIMEOUT_EN.

package bus_if_types_pkg;
   typedef enum logic [1:0] {TSIZE_BYTE, TSIZE_HALF, TSIZE_WORD} tsize_e;
   typedef enum logic       {TTYPE_READ, TTYPE_WRITE}            ttype_e;
endpackage

module bus_arbiter
   import bus_if_types_pkg::*;
#(
   parameter int unsigned FIXED_PRIO     = 0,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        bclk,
   input  logic        brst,

   input  logic        m0_breq,
   output logic        m0_bgnt,
   input  logic        m0_bstart,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  tsize_e      m0_tsize,
   input  ttype_e      m0_ttype,
   output logic [31:0] m0_rdata,
   output logic        m0_berror,
   output logic        m0_bdone,

   input  logic        m1_breq,
   output logic        m1_bgnt,
   input  logic        m1_bstart,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  tsize_e      m1_tsize,
   input  ttype_e      m1_ttype,
   output logic [31:0] m1_rdata,
   output logic        m1_berror,
   output logic        m1_bdone,

   output logic        s_bstart,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output tsize_e      s_tsize,
   output ttype_e      s_ttype,
   input  logic [31:0] s_rdata,
   input  logic        s_berror,
   input  logic        s_bdone
);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("bus_arbiter: TIMEOUT_CYCLES must be in 2..65535");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_BUSY} state_e;

   state_e r_state;
   logic   r_owner;
   logic   r_rr_last;

   logic        w_both_req;
   logic        w_any_req;
   logic        w_win_idle;
   logic        w_win_done;
   logic        w_own_breq;
   logic        w_own_bstart;
   logic        w_busy;
   logic        w_to_fire;
   logic        w_done;
   logic [31:0] w_rdata_ret;
   logic        w_berror_ret;

   assign w_both_req   = m0_breq & m1_breq;
   assign w_any_req    = m0_breq | m1_breq;
   assign w_own_breq   = r_owner ? m1_breq   : m0_breq;
   assign w_own_bstart = r_owner ? m1_bstart : m0_bstart;
   assign w_busy       = (r_state == ST_BUSY);

   // Completion re-arbitration uses rr_last as it will be after this cycle (= current owner).
   assign w_win_idle = w_both_req ? ((FIXED_PRIO != 0) ? 1'b0 : ~r_rr_last) : m1_breq;
   assign w_win_done = w_both_req ? ((FIXED_PRIO != 0) ? 1'b0 : ~r_owner)   : m1_breq;

`ifdef BUS_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] r_to_cnt;

   always_ff @(posedge bclk) begin
      if (brst || !w_busy) begin
         r_to_cnt <= '0;
      end else if (!s_bdone) begin
         r_to_cnt <= r_to_cnt + 16'd1;
      end
   end

   assign w_to_fire = w_busy && !s_bdone && (r_to_cnt == TO_LAST);
`else
   assign w_to_fire = 1'b0;
`endif

   assign w_done       = w_busy && (s_bdone || w_to_fire);
   assign w_rdata_ret  = w_to_fire ? '0 : s_rdata;
   assign w_berror_ret = w_to_fire | s_berror;

   always_ff @(posedge bclk) begin
      if (brst) begin
         r_state   <= ST_IDLE;
         r_owner   <= 1'b0;
         r_rr_last <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_owner <= w_win_idle;
                  r_state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (w_own_bstart) begin
                  r_state <= ST_BUSY;
               end else if (!w_own_breq) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (w_done) begin
                  r_rr_last <= r_owner;
                  if (w_any_req) begin
                     r_owner <= w_win_done;
                     r_state <= ST_GRANT;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign m0_bgnt = (r_state != ST_IDLE) && !r_owner;
   assign m1_bgnt = (r_state != ST_IDLE) &&  r_owner;

   always_comb begin
      s_bstart = (r_state == ST_GRANT) && w_own_bstart;
      s_addr   = '0;
      s_wdata  = '0;
      s_tsize  = TSIZE_BYTE;
      s_ttype  = TTYPE_READ;
      if (r_state != ST_IDLE) begin
         s_addr  = r_owner ? m1_addr  : m0_addr;
         s_wdata = r_owner ? m1_wdata : m0_wdata;
         s_tsize = r_owner ? m1_tsize : m0_tsize;
         s_ttype = r_owner ? m1_ttype : m0_ttype;
      end
   end

   always_comb begin
      m0_bdone  = 1'b0;
      m0_berror = 1'b0;
      m0_rdata  = '0;
      m1_bdone  = 1'b0;
      m1_berror = 1'b0;
      m1_rdata  = '0;
      if (w_busy) begin
         if (r_owner) begin
            m1_bdone  = w_done;
            m1_berror = w_berror_ret;
            m1_rdata  = w_rdata_ret;
         end else begin
            m0_bdone  = w_done;
            m0_berror = w_berror_ret;
            m0_rdata  = w_rdata_ret;
         end
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: round-robin instance (a_) and fixed-priority instance (b_)
// share stimulus. Watchdog vectors compile in with BUS_ARB_TIMEOUT_EN.

module tb_bus_arbiter;
   import bus_if_types_pkg::*;

   logic bclk = 1'b0;
   logic brst = 1'b1;

   logic        m0_breq = 0, m0_bstart = 0, m1_breq = 0, m1_bstart = 0;
   logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
   tsize_e      m0_tsize = TSIZE_BYTE, m1_tsize = TSIZE_BYTE;
   ttype_e      m0_ttype = TTYPE_READ, m1_ttype = TTYPE_READ;
   logic [31:0] s_rdata = '0;
   logic        s_berror = 0, s_bdone = 0;

   logic        a_m0_bgnt, a_m0_berror, a_m0_bdone, a_m1_bgnt, a_m1_berror, a_m1_bdone, a_s_bstart;
   logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata;
   tsize_e      a_s_tsize;
   ttype_e      a_s_ttype;
   logic        b_m0_bgnt, b_m0_berror, b_m0_bdone, b_m1_bgnt, b_m1_berror, b_m1_bdone, b_s_bstart;
   logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
   tsize_e      b_s_tsize;
   ttype_e      b_s_ttype;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 bclk = ~bclk;

   bus_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(8)) u_rr (
      .bclk(bclk), .brst(brst),
      .m0_breq(m0_breq), .m0_bgnt(a_m0_bgnt), .m0_bstart(m0_bstart), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_tsize(m0_tsize), .m0_ttype(m0_ttype), .m0_rdata(a_m0_rdata),
      .m0_berror(a_m0_berror), .m0_bdone(a_m0_bdone),
      .m1_breq(m1_breq), .m1_bgnt(a_m1_bgnt), .m1_bstart(m1_bstart), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_tsize(m1_tsize), .m1_ttype(m1_ttype), .m1_rdata(a_m1_rdata),
      .m1_berror(a_m1_berror), .m1_bdone(a_m1_bdone),
      .s_bstart(a_s_bstart), .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_tsize(a_s_tsize),
      .s_ttype(a_s_ttype), .s_rdata(s_rdata), .s_berror(s_berror), .s_bdone(s_bdone)
   );

   bus_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(8)) u_fp (
      .bclk(bclk), .brst(brst),
      .m0_breq(m0_breq), .m0_bgnt(b_m0_bgnt), .m0_bstart(m0_bstart), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_tsize(m0_tsize), .m0_ttype(m0_ttype), .m0_rdata(b_m0_rdata),
      .m0_berror(b_m0_berror), .m0_bdone(b_m0_bdone),
      .m1_breq(m1_breq), .m1_bgnt(b_m1_bgnt), .m1_bstart(m1_bstart), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_tsize(m1_tsize), .m1_ttype(m1_ttype), .m1_rdata(b_m1_rdata),
      .m1_berror(b_m1_berror), .m1_bdone(b_m1_bdone),
      .s_bstart(b_s_bstart), .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_tsize(b_s_tsize),
      .s_ttype(b_s_ttype), .s_rdata(s_rdata), .s_berror(s_berror), .s_bdone(s_bdone)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
   task automatic nxt();
      @(posedge bclk);
      #1;
   endtask

   task automatic mid();
      @(negedge bclk);
   endtask

   initial begin
      logic exp_own;

      nxt(); nxt();
      brst = 1'b0;
      mid();
      chk("rst_m0_bgnt", 32'(a_m0_bgnt), 32'd0);
      chk("rst_m1_bgnt", 32'(a_m1_bgnt), 32'd0);
      chk("rst_s_bstart", 32'(a_s_bstart), 32'd0);
      chk("rst_s_addr", a_s_addr, 32'd0);
      chk("rst_m0_bdone", 32'(a_m0_bdone), 32'd0);

      // Single transaction by m0
      nxt();
      m0_breq = 1; m0_addr = 32'h0000_1000; m0_wdata = 32'h1234_5678;
      m0_tsize = TSIZE_WORD; m0_ttype = TTYPE_WRITE;
      mid();
      chk("t1_bgnt_not_yet", 32'(a_m0_bgnt), 32'd0);
      nxt();
      mid();
      chk("t1_m0_bgnt", 32'(a_m0_bgnt), 32'd1);
      chk("t1_m1_bgnt", 32'(a_m1_bgnt), 32'd0);
      nxt();
      m0_bstart = 1;
      mid();
      chk("t1_s_bstart", 32'(a_s_bstart), 32'd1);
      chk("t1_s_addr", a_s_addr, 32'h0000_1000);
      chk("t1_s_wdata", a_s_wdata, 32'h1234_5678);
      chk("t1_s_tsize", 32'(a_s_tsize), 32'(TSIZE_WORD));
      chk("t1_s_ttype", 32'(a_s_ttype), 32'(TTYPE_WRITE));
      nxt();
      m0_bstart = 0; m0_breq = 0;
      mid();
      chk("t1_busy_s_bstart", 32'(a_s_bstart), 32'd0);
      chk("t1_busy_s_addr", a_s_addr, 32'h0000_1000);
      chk("t1_busy_m0_bgnt", 32'(a_m0_bgnt), 32'd1);
      chk("t1_busy_no_bdone", 32'(a_m0_bdone), 32'd0);
      nxt(); nxt();
      s_bdone = 1; s_rdata = 32'hDEAD_BEEF;
      mid();
      chk("t1_m0_bdone", 32'(a_m0_bdone), 32'd1);
      chk("t1_m0_rdata", a_m0_rdata, 32'hDEAD_BEEF);
      chk("t1_m0_berror", 32'(a_m0_berror), 32'd0);
      chk("t1_m1_bdone", 32'(a_m1_bdone), 32'd0);
      chk("t1_m1_rdata", a_m1_rdata, 32'd0);
      nxt();
      s_bdone = 1; s_rdata = 32'h0000_CAFE;
      mid();
      chk("t1_idle_m0_bgnt", 32'(a_m0_bgnt), 32'd0);
      chk("t1_idle_bdone_dropped", 32'(a_m0_bdone), 32'd0);
      chk("t1_idle_rdata_dropped", a_m0_rdata, 32'd0);
      chk("t1_idle_s_addr", a_s_addr, 32'd0);
      nxt();
      s_bdone = 0; s_rdata = 0;

      // Both masters requesting, four back-to-back transactions after a fresh reset
      brst = 1;
      nxt();
      brst = 0;
      m0_addr = 32'h0000_00A0; m1_addr = 32'h0000_00B1;
      m0_breq = 1; m1_breq = 1;
      nxt();
      for (int k = 0; k < 4; k++) begin
         exp_own = (k % 2 == 1);
         m0_bstart = 1; m1_bstart = 1;
         mid();
         chk($sformatf("rr%0d_m0_bgnt", k), 32'(a_m0_bgnt), 32'(!exp_own));
         chk($sformatf("rr%0d_m1_bgnt", k), 32'(a_m1_bgnt), 32'(exp_own));
         chk($sformatf("rr%0d_s_bstart", k), 32'(a_s_bstart), 32'd1);
         chk($sformatf("rr%0d_s_addr", k), a_s_addr, exp_own ? 32'h0000_00B1 : 32'h0000_00A0);
         chk($sformatf("fp%0d_m0_bgnt", k), 32'(b_m0_bgnt), 32'd1);
         chk($sformatf("fp%0d_s_addr", k), b_s_addr, 32'h0000_00A0);
         nxt();
         m0_bstart = 0; m1_bstart = 0;
         s_bdone = 1; s_rdata = 32'h100 + 32'(k);
         mid();
         chk($sformatf("rr%0d_m0_bdone", k), 32'(a_m0_bdone), 32'(!exp_own));
         chk($sformatf("rr%0d_m1_bdone", k), 32'(a_m1_bdone), 32'(exp_own));
         chk($sformatf("fp%0d_m0_bdone", k), 32'(b_m0_bdone), 32'd1);
         chk($sformatf("fp%0d_m1_bdone", k), 32'(b_m1_bdone), 32'd0);
         nxt();
         s_bdone = 0; s_rdata = 0;
      end
      m0_breq = 0; m1_breq = 0;
      nxt();
      mid();
      chk("rr_end_m0_bgnt", 32'(a_m0_bgnt), 32'd0);
      chk("rr_end_m1_bgnt", 32'(a_m1_bgnt), 32'd0);

      // m1 owns the bus; m0 strobes bstart in GRANT and BUSY
      nxt();
      m1_breq = 1; m1_addr = 32'h0000_2000; m0_addr = 32'h0000_3000;
      nxt();
      m0_bstart = 1;
      mid();
      chk("t3_grant_m1_bgnt", 32'(a_m1_bgnt), 32'd1);
      chk("t3_grant_nonowner_bstart", 32'(a_s_bstart), 32'd0);
      nxt();
      m0_bstart = 0; m1_bstart = 1;
      mid();
      chk("t3_s_bstart", 32'(a_s_bstart), 32'd1);
      chk("t3_s_addr", a_s_addr, 32'h0000_2000);
      nxt();
      m1_bstart = 0; m0_bstart = 1;
      mid();
      chk("t3_busy_s_bstart", 32'(a_s_bstart), 32'd0);
      chk("t3_busy_s_addr", a_s_addr, 32'h0000_2000);
      chk("t3_busy_m0_bgnt", 32'(a_m0_bgnt), 32'd0);
      nxt();
      m0_bstart = 0; m1_breq = 0;
      s_bdone = 1; s_berror = 1; s_rdata = 32'h0000_55AA;
      mid();
      chk("t3_m1_bdone", 32'(a_m1_bdone), 32'd1);
      chk("t3_m1_berror", 32'(a_m1_berror), 32'd1);
      chk("t3_m1_rdata", a_m1_rdata, 32'h0000_55AA);
      chk("t3_m0_bdone", 32'(a_m0_bdone), 32'd0);
      chk("t3_m0_berror", 32'(a_m0_berror), 32'd0);
      chk("t3_m0_rdata", a_m0_rdata, 32'd0);
      nxt();
      s_bdone = 0; s_berror = 0; s_rdata = 0;

      // Granted m0 withdraws without starting; m1 then requests
      m0_breq = 1;
      nxt();
      m0_breq = 0;
      mid();
      chk("t4_m0_bgnt", 32'(a_m0_bgnt), 32'd1);
      nxt();
      m1_breq = 1;
      mid();
      chk("t4_idle_m0_bgnt", 32'(a_m0_bgnt), 32'd0);
      chk("t4_idle_m1_bgnt", 32'(a_m1_bgnt), 32'd0);
      nxt();
      mid();
      chk("t4_m1_bgnt", 32'(a_m1_bgnt), 32'd1);
      m1_breq = 0;
      nxt();

      // Reset during BUSY, then a late s_bdone
      m0_breq = 1;
      nxt();
      m0_bstart = 1;
      nxt();
      m0_bstart = 0; m0_breq = 0; brst = 1;
      nxt();
      brst = 0; s_bdone = 1; s_rdata = 32'h0000_0077; m1_breq = 1;
      mid();
      chk("t5_m0_bgnt", 32'(a_m0_bgnt), 32'd0);
      chk("t5_m1_bgnt", 32'(a_m1_bgnt), 32'd0);
      chk("t5_m0_bdone", 32'(a_m0_bdone), 32'd0);
      chk("t5_m0_rdata", a_m0_rdata, 32'd0);
      chk("t5_s_bstart", 32'(a_s_bstart), 32'd0);
      nxt();
      s_bdone = 0; s_rdata = 0;
      mid();
      chk("t5_m1_wins", 32'(a_m1_bgnt), 32'd1);
      m1_breq = 0;
      nxt();

`ifdef BUS_ARB_TIMEOUT_EN
      // Watchdog: no s_bdone after start, TIMEOUT_CYCLES = 8
      m0_breq = 1;
      nxt();
      m0_bstart = 1;
      nxt();
      m0_bstart = 0; m0_breq = 0; m1_breq = 1; s_rdata = 32'hFFFF_0000;
      for (int i = 1; i < 8; i++) begin
         mid();
         chk($sformatf("to_early_%0d", i), 32'(a_m0_bdone), 32'd0);
         nxt();
      end
      mid();
      chk("to_m0_bdone", 32'(a_m0_bdone), 32'd1);
      chk("to_m0_berror", 32'(a_m0_berror), 32'd1);
      chk("to_m0_rdata", a_m0_rdata, 32'd0);
      chk("to_m1_bdone", 32'(a_m1_bdone), 32'd0);
      nxt();
      s_rdata = 0;
      mid();
      chk("to_rearb_m1_bgnt", 32'(a_m1_bgnt), 32'd1);
      m1_breq = 0;
      nxt();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one downstream master-side bus port between two bus masters, m0 and m1. Typical pairing: instruction fetch and load/store unit.
- Uses the codebase's breq/bgnt/bstart/bdone handshake on both sides.
- Sits between the masters and the interconnect's master port.
- Round-robin or fixed-priority arbitration, one outstanding transaction at a time.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin; 1 = m0 always wins when both request.
- TIMEOUT_CYCLES, 256: BUSY-cycle limit before abort. Only used with BUS_ARB_TIMEOUT_EN; legal range 2..65535.

Ports:
- bclk  in  1  bus clock; all logic on rising edge.
- brst  in  1  synchronous active-high reset.
- mN_breq  in  1  master N requests the bus (N = 0, 1; all mN_ lines exist for both masters).
- mN_bgnt  out  1  master N owns the bus.
- mN_bstart  in  1  master N transaction start pulse.
- mN_addr  in  32  master N address.
- mN_wdata  in  32  master N write data.
- mN_tsize  in  tsize_e  master N transfer size (bus_if_types_pkg).
- mN_ttype  in  ttype_e  master N transfer type (bus_if_types_pkg).
- mN_rdata  out  32  read data returned to master N.
- mN_berror  out  1  error returned to master N.
- mN_bdone  out  1  completion pulse to master N.
- s_bstart  out  1  downstream start.
- s_addr  out  32  downstream address.
- s_wdata  out  32  downstream write data.
- s_tsize  out  tsize_e  downstream transfer size.
- s_ttype  out  ttype_e  downstream transfer type.
- s_rdata  in  32  downstream read data.
- s_berror  in  1  downstream error.
- s_bdone  in  1  downstream completion pulse.

Behaviour:
- States: IDLE, GRANT, BUSY. Registered: owner (1 bit), rr_last (1 bit).
- Reset: state IDLE, owner 0, rr_last 1 (m0 wins first tie), both bgnt 0, s_bstart 0, both mN_bdone 0, both mN_berror 0. brst dominates everything in any state; an in-flight transaction is abandoned.
- Winner rule:
  - Single requester wins.
  - Both requesting: FIXED_PRIO=1 -> m0; FIXED_PRIO=0 -> the master != rr_last.
- IDLE:
  - Any breq -> owner <= winner, state GRANT; mN_bgnt rises next cycle (breq->bgnt latency 1 cycle).
  - mN_bstart, s_bdone ignored.
- bgnt is registered: mN_bgnt = (state != IDLE) && owner == N. Never both high.
- GRANT:
  - Owner bstart=1 -> s_bstart=1 combinationally in the same cycle; state BUSY.
  - Owner breq=0 with no bstart -> state IDLE; bgnt falls next cycle.
  - Non-owner bstart ignored.
- Request mux: s_addr/s_wdata/s_tsize/s_ttype = owner's signals in GRANT and BUSY. In IDLE they are 0 / first enum value.
- s_bstart is only ever high in GRANT; it is a one-cycle pulse.
- Owner holds addr/wdata/tsize/ttype stable until bdone.
- BUSY:
  - s_bstart=0.
  - s_bdone/s_rdata/s_berror route combinationally to the owner only; the non-owner sees bdone=0, berror=0, rdata=0.
  - On s_bdone: rr_last <= owner. Then:
    - if any breq (evaluated with the updated rr_last): owner <= winner, state GRANT (back-to-back, no idle cycle);
    - else state IDLE.
- Combinational loop on s_bdone->bstart is forbidden: bstart is only accepted in GRANT.
- s_bdone in IDLE/GRANT: dropped; no master sees it.
- Same-cycle s_bdone and a new breq: handled by the BUSY rule above.

Optional Feature:
- BUS_ARB_TIMEOUT_EN defined:
  - 16-bit counter clears on entry to BUSY and increments each BUSY cycle without s_bdone.
  - On reaching TIMEOUT_CYCLES-1: owner gets bdone=1, berror=1, rdata=0 for one cycle, and the block proceeds exactly as on s_bdone.
  - A late s_bdone is attributed by state only; downstream slaves must complete within TIMEOUT_CYCLES.
- Undefined: no counter; BUSY waits for s_bdone indefinitely.

Test Plan:
- Reset then m0_breq=1 at cycle 0 -> m0_bgnt=1 at cycle 1. m0_bstart with addr 0x0000_1000 at cycle 2 -> s_bstart=1, s_addr=0x1000 same cycle. s_bdone with s_rdata 0xDEADBEEF at cycle 5 -> m0_bdone=1, m0_rdata=0xDEADBEEF; m1 outputs 0.
- Both breq held, FIXED_PRIO=0 -> grants alternate m0,m1,m0,m1 across 4 transactions, back-to-back with no IDLE cycle. FIXED_PRIO=1 -> m0 for all 4.
- m1 owns bus in BUSY, m0 bstart pulses -> s_bstart stays 0, s_addr stays m1_addr.
- m0 granted, drops breq without bstart -> state IDLE, m0_bgnt=0 next cycle. m1_breq then gets bgnt 1 cycle after IDLE.
- brst=1 during BUSY, followed by s_bdone=1 -> all bgnt/bdone 0; s_bdone dropped; the next m1 request wins only if m0 idle.
- BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no s_bdone -> owner bdone=1, berror=1 exactly 8 cycles after s_bstart; arbiter re-arbitrates.
